// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack; overwrites the oldest entry on overflow and refuses to pop when empty.
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int XLEN = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     call_i,
  input  logic                     return_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic                     flush_i,
  output logic [XLEN-1:0]          ret_addr_o,
  output logic                     ret_vld_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0] tos, tos_inc, tos_dec;
  logic [AW:0] count;
  logic [XLEN-1:0] link;
  assign link = pc_i + XLEN'(4);
  assign tos_inc = tos + AW'(1);
  assign tos_dec = tos - AW'(1);
  assign empty_o = count == '0;
  assign full_o = count == (AW+1)'(DEPTH);
  assign count_o = count;
  assign ret_addr_o = mem[tos];
  assign ret_vld_o = return_i && !empty_o;
  // A call+return on an empty stack falls through to the plain-call branch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tos <= AW'(DEPTH-1);
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else if (call_i && return_i && !empty_o) begin
      mem[tos] <= link;
    end else if (call_i) begin
      tos <= tos_inc;
      mem[tos_inc] <= link;
      count <= full_o ? count : count + 1'b1;
    end else if (return_i && !empty_o) begin
      tos <= tos_dec;
      count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: directed checks of push/pop, overflow, swap, flush, wrap and async reset.
module tb_return_addr_stack;
  logic clk = 0, rst = 1, call = 0, ret = 0, flush = 0;
  logic [31:0] pc = 0, ret_addr;
  logic ret_vld, empty, full;
  logic [3:0] count;
  int passed = 0, total = 0;

  return_addr_stack #(.DEPTH(8), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .call_i(call), .return_i(ret), .pc_i(pc),
    .flush_i(flush), .ret_addr_o(ret_addr), .ret_vld_o(ret_vld),
    .empty_o(empty), .full_o(full), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic r, input logic f, input logic [31:0] p);
    call = c;
    ret = r;
    flush = f;
    pc = p;
  endtask

  initial begin
    #1;
    chk("rst_addr", ret_addr, 0);
    chk("rst_vld", {31'b0, ret_vld}, 0);
    chk("rst_empty", {31'b0, empty}, 1);
    chk("rst_full", {31'b0, full}, 0);
    chk("rst_count", {28'b0, count}, 0);
    #11 rst = 0;
    cyc();
    drive(0, 1, 0, 32'h100);
    #1;
    chk("empty_ret_vld", {31'b0, ret_vld}, 0);
    chk("empty_ret_cnt", {28'b0, count}, 0);
    cyc();
    chk("empty_ret_hold", {28'b0, count}, 0);
    drive(1, 0, 0, 32'h1000); cyc();
    drive(1, 0, 0, 32'h2000); cyc();
    drive(1, 0, 0, 32'h3000); cyc();
    chk("push3_cnt", {28'b0, count}, 3);
    drive(0, 1, 0, 0); #1;
    chk("pop1_addr", ret_addr, 32'h3004);
    chk("pop1_vld", {31'b0, ret_vld}, 1);
    cyc();
    chk("pop2_addr", ret_addr, 32'h2004);
    chk("pop2_vld", {31'b0, ret_vld}, 1);
    cyc();
    chk("pop3_addr", ret_addr, 32'h1004);
    chk("pop3_vld", {31'b0, ret_vld}, 1);
    cyc();
    chk("pop4_vld", {31'b0, ret_vld}, 0);
    chk("pop4_empty", {31'b0, empty}, 1);
    cyc();
    chk("pop4_cnt", {28'b0, count}, 0);
    for (int k = 1; k <= 10; k++) begin
      drive(1, 0, 0, 32'h10 * k);
      cyc();
    end
    drive(0, 0, 0, 0); #1;
    chk("ovf_full", {31'b0, full}, 1);
    chk("ovf_cnt", {28'b0, count}, 8);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("ovf_pop%0d", i), ret_addr, 32'h10 * (10 - i) + 4);
      chk($sformatf("ovf_vld%0d", i), {31'b0, ret_vld}, 1);
      cyc();
    end
    #1;
    chk("ovf_drained_vld", {31'b0, ret_vld}, 0);
    chk("ovf_drained_empty", {31'b0, empty}, 1);
    drive(1, 0, 0, 32'h500); cyc();
    drive(1, 1, 0, 32'h800); #1;
    chk("swap_old_addr", ret_addr, 32'h504);
    chk("swap_vld", {31'b0, ret_vld}, 1);
    cyc();
    drive(0, 0, 0, 0); #1;
    chk("swap_new_addr", ret_addr, 32'h804);
    chk("swap_cnt", {28'b0, count}, 1);
    drive(0, 1, 0, 0); cyc();
    chk("swap_drain", {28'b0, count}, 0);
    drive(1, 0, 0, 32'h10); cyc();
    drive(1, 0, 0, 32'h20); cyc();
    drive(1, 0, 0, 32'h30); cyc();
    drive(1, 0, 1, 32'h900); cyc();
    drive(0, 0, 0, 0); #1;
    chk("flush_cnt", {28'b0, count}, 0);
    chk("flush_empty", {31'b0, empty}, 1);
    chk("flush_no_push", ret_addr, 32'h34);
    drive(0, 1, 0, 0); #1;
    chk("flush_ret_vld", {31'b0, ret_vld}, 0);
    cyc();
    drive(1, 0, 0, 32'hFFFF_FFFC); cyc();
    drive(0, 0, 0, 0); #1;
    chk("wrap_addr", ret_addr, 0);
    chk("wrap_cnt", {28'b0, count}, 1);
    for (int k = 1; k <= 3; k++) begin
      drive(1, 0, 0, 32'h40 * k);
      cyc();
    end
    drive(0, 0, 0, 0); #1;
    chk("pre_rst_cnt", {28'b0, count}, 4);
    #1 rst = 1;
    #1;
    chk("async_rst_cnt", {28'b0, count}, 0);
    chk("async_rst_empty", {31'b0, empty}, 1);
    chk("async_rst_addr", ret_addr, 0);
    #1 rst = 0;
    cyc();
    chk("post_rst_cnt", {28'b0, count}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
